ccff_bitstream_loader: RTL and testbench

//  Upstream feeder of a tile configuration chain (ccff_head -> ... -> ccff_tail).

---
 rtl/ccff_loader_pkg.sv | 16 +
 rtl/ccff_tail_crc16.sv | 35 +++
 rtl/ccff_bitstream_loader.sv | 133 +++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One MSB-first CRC-16-CCITT step for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_tail_crc16.sv
// Serial-in CRC-16-CCITT accumulator with synchronous clear and bit enable.
module ccff_tail_crc16
  import ccff_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        pReset_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        din_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC16_INIT;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, din_i);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Feeds a configuration chain: takes words over valid/ready and shifts CHAIN_LEN bits
// MSB-first onto ccff_head. Define CCFF_TAIL_SIG_EN to add a CRC-16 signature of ccff_tail.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 18,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       tail_sig
);

  localparam int REM_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  state_e            state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [REM_W-1:0]  rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              last_q;
  logic              cfg_ready_q;
  logic              ccff_head_q;
  logic              config_enable_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  assign cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);

  // cnt_q counts bits already presented on ccff_head, including the one shown this cycle.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state_q         <= IDLE;
      sreg_q          <= '0;
      rem_q           <= '0;
      cnt_q           <= '0;
      last_q          <= 1'b0;
      cfg_ready_q     <= 1'b0;
      ccff_head_q     <= 1'b0;
      config_enable_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= LOAD;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
          end
        end
        LOAD: begin
          if (cfg_valid && cfg_ready_q) begin
            state_q         <= SHIFT;
            cfg_ready_q     <= 1'b0;
            last_q          <= cfg_last;
            ccff_head_q     <= cfg_data[WORD_W-1];
            config_enable_q <= 1'b1;
            sreg_q          <= cfg_data << 1;
            rem_q           <= REM_W'(WORD_W - 1);
            cnt_q           <= cnt_d;
          end
        end
        SHIFT: begin
          // Reaching the chain length takes priority over an exhausted last word.
          if (cnt_q == CNT_FULL || (rem_q == '0 && last_q)) begin
            state_q         <= DONE;
            config_enable_q <= 1'b0;
            ccff_head_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
            err_q           <= (cnt_q == CNT_FULL) ? !last_q : 1'b1;
          end else if (rem_q == '0) begin
            state_q         <= LOAD;
            cfg_ready_q     <= 1'b1;
            config_enable_q <= 1'b0;
            ccff_head_q     <= 1'b0;
          end else begin
            ccff_head_q <= sreg_q[WORD_W-1];
            sreg_q      <= sreg_q << 1;
            rem_q       <= rem_q - REM_W'(1);
            cnt_q       <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign ccff_head     = ccff_head_q;
  assign config_enable = config_enable_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

`ifdef CCFF_TAIL_SIG_EN
  logic tail_clr;
  assign tail_clr = start && (state_q == IDLE || state_q == DONE);

  ccff_tail_crc16 u_tail_crc (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .clr_i    (tail_clr),
    .en_i     (config_enable_q),
    .din_i    (ccff_tail),
    .crc_o    (tail_sig)
  );
`else
  logic tail_unused;
  assign tail_unused = ccff_tail;
  assign tail_sig    = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench: two loaders (18-bit and 40-bit chains), directed table plus random loads.
module tb_ccff_bitstream_loader;

  logic        prog_clk;
  logic        rst_n [2];
  logic        start [2];
  logic        valid [2];
  logic        last  [2];
  logic        ready [2];
  logic        head  [2];
  logic        en    [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];
  logic [31:0] data  [2];
  logic [15:0] sig   [2];

  logic [17:0] chain0 = '0;
  logic        tail0;
  logic        tail1;
  assign tail0 = chain0[17];
  assign tail1 = 1'b0;

  always @(posedge prog_clk) if (en[0] === 1'b1) chain0 <= {chain0[16:0], head[0]};

  ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(18), .CNT_W(16)) dut18 (
    .prog_clk(prog_clk), .pReset_n(rst_n[0]), .start(start[0]), .cfg_valid(valid[0]),
    .cfg_ready(ready[0]), .cfg_data(data[0]), .cfg_last(last[0]), .ccff_head(head[0]),
    .config_enable(en[0]), .ccff_tail(tail0), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .tail_sig(sig[0]));

  ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(40), .CNT_W(16)) dut40 (
    .prog_clk(prog_clk), .pReset_n(rst_n[1]), .start(start[1]), .cfg_valid(valid[1]),
    .cfg_ready(ready[1]), .cfg_data(data[1]), .cfg_last(last[1]), .ccff_head(head[1]),
    .config_enable(en[1]), .ccff_tail(tail1), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .tail_sig(sig[1]));

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  typedef struct {
    int          inst;
    int          nw;
    logic [31:0] w0, w1, w2;
    int          li;
    int          exp_n;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] wq [3];
  bit          got [$];
  bit          hist0 [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // CRC-16-CCITT, init 0xFFFF, by polynomial long division (message length >= 16).
  function automatic logic [15:0] crc_ref(input bit msg[$]);
    bit          m[$];
    logic [16:0] p;
    logic [15:0] r;
    p = 17'h11021;
    m = msg;
    for (int k = 0; k < 16 && k < m.size(); k++) m[k] = ~m[k];
    for (int k = 0; k < 16; k++) m.push_back(1'b0);
    for (int k = 0; k + 16 < m.size(); k++)
      if (m[k]) for (int j = 0; j <= 16; j++) m[k+j] = m[k+j] ^ p[16-j];
    r = '0;
    for (int k = m.size() - 16; k < m.size(); k++) r = {r[14:0], m[k]};
    return r;
  endfunction

  // Expected shifted bits, error flag and words consumed, from chain length and last index.
  task automatic model(input int len, input int li, output int n, output bit e, output int w);
    int needed;
    needed = (len + 31) / 32;
    if (li >= 0 && li + 1 < needed) begin
      n = (li + 1) * 32; e = 1'b1; w = li + 1;
    end else begin
      n = len; e = (li != needed - 1); w = needed;
    end
  endtask

  task automatic do_load(input int i, input int nw, input int li, input int gap, input bit poke,
                         input int exp_n, input bit exp_err, input int exp_words, input bit chk_bub);
    int          wi, cyc, bub;
    bit          tb_bits[$];
    logic [63:0] exp_v, got_v;
    logic [15:0] exp_sig;
    got.delete();
    for (int k = 0; k < exp_n; k++)
      tb_bits.push_back((i == 0) ? hist0[hist0.size() - 18 + k] : 1'b0);
`ifdef CCFF_TAIL_SIG_EN
    exp_sig = crc_ref(tb_bits);
`else
    exp_sig = 16'h0000;
`endif
    @(negedge prog_clk); start[i] = 1'b1;
    @(negedge prog_clk); start[i] = 1'b0;
    wi = 0; cyc = 0; bub = 0;
    while (done[i] !== 1'b1) begin
      if (en[i] === 1'b1) got.push_back(head[i]);
      else if (got.size() > 0) bub++;
      start[i] = poke && (cyc == 3);
      valid[i] = 1'b0;
      if (wi < nw && int'($urandom_range(0, 99)) >= gap) begin
        valid[i] = 1'b1; data[i] = wq[wi]; last[i] = (wi == li);
        if (ready[i] === 1'b1) wi++;
      end
      @(negedge prog_clk);
      cyc++;
      if (cyc > 300) begin
        check("load_timeout", 1, 0);
        break;
      end
    end
    valid[i] = 1'b0; start[i] = 1'b0;
    exp_v = '0; got_v = '0;
    for (int k = 0; k < exp_n; k++) exp_v = {exp_v[62:0], wq[k/32][31 - k%32]};
    for (int k = 0; k < got.size() && k < 64; k++) got_v = {got_v[62:0], got[k]};
    $display("load inst=%0d words=%0d/%0d bits=%0d bubbles=%0d done=%0b err=%0b sig=%04h",
             i, wi, nw, got.size(), bub, done[i], err[i], sig[i]);
    check("bit_count", got.size(), exp_n);
    check("bit_stream", got_v, exp_v);
    check("err_flag", err[i], exp_err);
    check("words_taken", wi, exp_words);
    if (chk_bub) check("bubbles", bub, exp_words - 1);
    check("done_en", en[i], 0);
    check("done_head", head[i], 0);
    check("done_busy", busy[i], 0);
    check("done_ready", ready[i], 0);
    check("tail_sig", sig[i], exp_sig);
    if (i == 0) begin
      for (int k = 0; k < exp_n; k++) hist0.push_back(exp_v[exp_n - 1 - k]);
      while (hist0.size() > 18) void'(hist0.pop_front());
    end
  endtask

  initial begin
    int nb, cyc;
    vecs[0] = '{0, 1, 32'hA5A5_0000, 32'h0, 32'h0, 0, 18, 1'b0, 1};
    vecs[1] = '{1, 2, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1, 40, 1'b0, 2};
    vecs[2] = '{1, 1, 32'h1234_5678, 32'h0, 32'h0, 0, 32, 1'b1, 1};
    vecs[3] = '{0, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, -1, 18, 1'b1, 1};
    vecs[4] = '{1, 3, 32'h0F0F_F0F0, 32'h3C3C_C3C3, 32'h5555_AAAA, 2, 40, 1'b1, 2};
    vecs[5] = '{1, 2, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0, 0, 32, 1'b1, 1};
    for (int k = 0; k < 18; k++) hist0.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; valid[i] = 1'b0; last[i] = 1'b0; data[i] = '0;
    end
    repeat (3) @(negedge prog_clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_head", head[i], 0);
      check("rst_en", en[i], 0);
      check("rst_ready", ready[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_done", done[i], 0);
      check("rst_err", err[i], 0);
      check("rst_sig", sig[i], 0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    for (int v = 0; v < 6; v++) begin
      wq[0] = vecs[v].w0; wq[1] = vecs[v].w1; wq[2] = vecs[v].w2;
      do_load(vecs[v].inst, vecs[v].nw, vecs[v].li, 0, 1'b0,
              vecs[v].exp_n, vecs[v].exp_err, vecs[v].exp_words, 1'b1);
    end

    // Reset in the middle of shifting, after five bits reached the chain.
    wq[0] = 32'hC3C3_1234;
    @(negedge prog_clk); start[0] = 1'b1;
    @(negedge prog_clk); start[0] = 1'b0; valid[0] = 1'b1; data[0] = wq[0]; last[0] = 1'b1;
    nb = 0; cyc = 0;
    while (nb < 5 && cyc < 50) begin
      @(negedge prog_clk); valid[0] = 1'b0; cyc++;
      if (en[0] === 1'b1) nb++;
    end
    check("midrst_bits", nb, 5);
    rst_n[0] = 1'b0;
    @(negedge prog_clk);
    $display("midreset inst=0 en=%0b busy=%0b done=%0b", en[0], busy[0], done[0]);
    check("midrst_en", en[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_ready", ready[0], 0);
    check("midrst_done", done[0], 0);
    check("midrst_head", head[0], 0);
    check("midrst_sig", sig[0], 0);
    rst_n[0] = 1'b1;
    for (int k = 0; k < 5; k++) hist0.push_back(wq[0][31 - k]);
    while (hist0.size() > 18) void'(hist0.pop_front());
    wq[0] = vecs[0].w0;
    do_load(0, 1, 0, 0, 1'b0, 18, 1'b0, 1, 1'b1);

    for (int r = 0; r < 24; r++) begin
      int i, li, n, w;
      bit e;
      i  = int'($urandom_range(0, 1));
      li = int'($urandom_range(0, 3)) - 1;
      for (int k = 0; k < 3; k++) wq[k] = $urandom;
      model((i == 0) ? 18 : 40, li, n, e, w);
      do_load(i, 3, li, 30, 1'($urandom_range(0, 1)), n, e, w, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
